// File: rtl/arbiter_rr_if.sv
// Request/grant bundle between NUM_REQ requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface arbiter_rr_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_valid;

    modport master (output req, input  gnt, gnt_id, gnt_valid);
    modport slave  (input  req, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/arbiter_rr.sv
// N-way round-robin arbiter with grant lock and registered outputs.
// Optional ARBITER_RR_HOLD_LIMIT_EN revokes a grant held MAX_HOLD cycles when others wait.
module arbiter_rr #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic        clock,
    input  logic        reset,
    arbiter_rr_if.slave bus
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W != $clog2(NUM_REQ) ||
        MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
        $error("arbiter_rr: illegal parameter combination");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic               gnt_valid_q;
    logic [ID_W-1:0]    ptr;

    logic [NUM_REQ-1:0] cand;
    logic [ID_W-1:0]    win_idx;
    logic               win_found;
    logic               owner_req;
    logic               revoke;

    assign owner_req = bus.req[gnt_id_q];
    // The owner bit is masked out: it is either already low, or being revoked.
    assign cand      = bus.req & ~gnt_q;

`ifdef ARBITER_RR_HOLD_LIMIT_EN
    logic [7:0] hold_cnt;
    assign revoke = (hold_cnt == 8'(MAX_HOLD)) && (|cand);
`else
    assign revoke = 1'b0;
`endif

    // Wrap-around search starting at ptr.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            ptr         <= '0;
`ifdef ARBITER_RR_HOLD_LIMIT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            if ((state == GRANT) && owner_req && !revoke) begin
`ifdef ARBITER_RR_HOLD_LIMIT_EN
                if (hold_cnt != 8'(MAX_HOLD)) hold_cnt <= hold_cnt + 8'd1;
`endif
            end else if (win_found) begin
                state       <= GRANT;
                gnt_q       <= NUM_REQ'(1) << win_idx;
                gnt_id_q    <= win_idx;
                gnt_valid_q <= 1'b1;
                ptr         <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
`ifdef ARBITER_RR_HOLD_LIMIT_EN
                hold_cnt    <= '0;
`endif
            end else begin
                // Nobody requesting: go idle, gnt_id keeps the last owner.
                state       <= IDLE;
                gnt_q       <= '0;
                gnt_valid_q <= 1'b0;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed-vector bench for arbiter_rr, NUM_REQ=4; hold-limit checks when
// ARBITER_RR_HOLD_LIMIT_EN is defined (MAX_HOLD=4).
module tb_arbiter_rr;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
`ifdef ARBITER_RR_HOLD_LIMIT_EN
    localparam int LOCK_CYC = 3;
`else
    localparam int LOCK_CYC = 20;
`endif

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    arbiter_rr_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    arbiter_rr #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_HOLD(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] g, input logic [1:0] id, input logic v);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".id"}, 32'(bus.gnt_id), 32'(id));
        chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(v));
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.req = 4'b1111;

        // reset held two edges
        step(); chk_gnt("rst0", 4'b0000, 2'd0, 1'b0);
        step(); chk_gnt("rst1", 4'b0000, 2'd0, 1'b0);
        reset = 1'b1;
        step(); chk_gnt("rst_rel", 4'b0001, 2'd0, 1'b1);

        // round-robin 0,1,2,3,0 with no idle bubbles
        step(); chk_gnt("rr0_hold", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b1110; step(); chk_gnt("rr1", 4'b0010, 2'd1, 1'b1);
        bus.req = 4'b1111; step(); chk_gnt("rr1_hold", 4'b0010, 2'd1, 1'b1);
        bus.req = 4'b1101; step(); chk_gnt("rr2", 4'b0100, 2'd2, 1'b1);
        bus.req = 4'b1111; step(); chk_gnt("rr2_hold", 4'b0100, 2'd2, 1'b1);
        bus.req = 4'b1011; step(); chk_gnt("rr3", 4'b1000, 2'd3, 1'b1);
        bus.req = 4'b1111; step(); chk_gnt("rr3_hold", 4'b1000, 2'd3, 1'b1);
        bus.req = 4'b0111; step(); chk_gnt("rr0_again", 4'b0001, 2'd0, 1'b1);

        // lock on requester 2 while 0 and 3 wait
        bus.req = 4'b0100; step(); chk_gnt("lock_get2", 4'b0100, 2'd2, 1'b1);
        bus.req = 4'b1101;
        for (int i = 0; i < LOCK_CYC; i++) begin
            step(); chk("lock_hold", 32'(bus.gnt), 32'h4);
        end
        bus.req = 4'b1001; step(); chk_gnt("lock_rel3", 4'b1000, 2'd3, 1'b1);
        bus.req = 4'b0001; step(); chk_gnt("lock_then0", 4'b0001, 2'd0, 1'b1);

        // wrap to 3, then idle keeps gnt_id
        bus.req = 4'b1000; step(); chk_gnt("wrap3", 4'b1000, 2'd3, 1'b1);
        bus.req = 4'b0000; step(); chk_gnt("idle", 4'b0000, 2'd3, 1'b0);
        step(); chk_gnt("idle2", 4'b0000, 2'd3, 1'b0);
        bus.req = 4'b1001; step(); chk_gnt("idle_to0", 4'b0001, 2'd0, 1'b1);

        // reset in the middle of a grant
        bus.req = 4'b0100; step(); chk_gnt("mid_get2", 4'b0100, 2'd2, 1'b1);
        step(); chk_gnt("mid_hold2", 4'b0100, 2'd2, 1'b1);
        reset = 1'b0; bus.req = 4'b0110;
        step(); chk_gnt("mid_rst", 4'b0000, 2'd0, 1'b0);
        reset = 1'b1;
        step(); chk_gnt("mid_after", 4'b0010, 2'd1, 1'b1);

        // ptr=2: requesters 0 and 3 together go to 3, not to lower index 0
        bus.req = 4'b1001; step(); chk_gnt("ptr_order", 4'b1000, 2'd3, 1'b1);
        bus.req = 4'b0001; step(); chk_gnt("ptr_next0", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b0000; step(); chk_gnt("ptr_idle", 4'b0000, 2'd0, 1'b0);

`ifdef ARBITER_RR_HOLD_LIMIT_EN
        reset = 1'b0; step();
        reset = 1'b1; bus.req = 4'b0010;
        step(); chk_gnt("hl_c1", 4'b0010, 2'd1, 1'b1);
        bus.req = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            step(); chk("hl_hold", 32'(bus.gnt), 32'h2);
        end
        step(); chk_gnt("hl_revoke", 4'b0100, 2'd2, 1'b1);
        bus.req = 4'b0010; step(); chk_gnt("hl_back1", 4'b0010, 2'd1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(); chk("hl_alone", 32'(bus.gnt), 32'h2);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- Parametrised N-way round-robin arbiter with grant lock; next generation of the team's 2-way fixed-priority arbiter.
- Arbitrates a shared resource (bus, memory port) among NUM_REQ requesters.
- Registered one-hot grant plus encoded grant index.
- The current owner keeps the grant while its request stays high. When it drops, the next grant goes round-robin from the slot after the previous winner.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, 2, width of gnt_id; must equal ceil(log2(NUM_REQ)).
- MAX_HOLD, 8, maximum consecutive grant cycles per owner; used only with ARBITER_RR_HOLD_LIMIT_EN; legal range 1..255.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low: reset==0 at a rising edge of clock resets the block
- req  input  NUM_REQ  request vector, bit i = requester i; level-sensitive
- gnt  output  NUM_REQ  registered one-hot grant vector; all-zero when idle
- gnt_id  output  ID_W  index of the granted requester; valid only when gnt_valid==1
- gnt_valid  output  1  1 when any gnt bit is set

Behaviour:
- Reset (reset==0 at a clock edge): gnt=0, gnt_id=0, gnt_valid=0, ptr=0, state=IDLE, hold_cnt=0. Reset overrides everything, including mid-grant; the next grant after reset starts searching from requester 0.
- All outputs are registered. Latency from req change to gnt change is 1 clock.
- State machine, evaluated at each rising edge with reset==1:
  - IDLE:
    - If req==0, stay in IDLE with gnt=0.
    - Else arbitrate, load the grant, go to GRANT.
  - GRANT:
    - If req[owner]==1, keep gnt, gnt_id and the state unchanged (lock).
    - If req[owner]==0 and other requests are pending, arbitrate and hand over on the same edge. There is no idle bubble between owners.
    - If req[owner]==0 and req==0, clear gnt and gnt_valid and go to IDLE.
- Arbitration:
  - Winner = first i with req[i]==1, searching i = ptr, ptr+1, ... NUM_REQ-1, then 0 ... ptr-1 (wrap-around).
  - On every new grant: ptr <= (winner+1) mod NUM_REQ. ptr after winner NUM_REQ-1 is 0.
  - ptr does not change while a grant is held or while idle.
- Simultaneous requests: resolved purely by ptr order, never by fixed index priority.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_id == index of the set gnt bit.
  - gnt_id holds its last value when gnt_valid==0.
- Request bits outside the current owner are ignored while the lock holds.
- Requester i is not guaranteed service until every earlier requester in ptr order has been served once.

Optional Feature:
- Macro: ARBITER_RR_HOLD_LIMIT_EN.
- Defined:
  - 8-bit hold_cnt clears on each new grant and increments each cycle the grant is held, saturating at MAX_HOLD.
  - When hold_cnt==MAX_HOLD and at least one other req bit is set, the grant is revoked at the next edge even if req[owner]==1. Arbitration then excludes the owner and searches from owner+1; ptr updates as normal.
  - If no other requester is pending, the owner keeps the grant and hold_cnt stays at MAX_HOLD.
  - An owner revoked while still requesting competes normally afterwards.
- Not defined: no hold_cnt logic; the lock is unbounded; MAX_HOLD is ignored.

Test Plan (NUM_REQ=4 unless stated):
- Reset: hold reset=0 for 2 edges with req=4'b1111, then release -> gnt=0, gnt_valid=0 during reset; first edge after release gives gnt=4'b0001, gnt_id=0.
- Round-robin: req=4'b1111 held, each owner drops its req for 1 cycle after 2 cycles of grant, then reasserts -> grant order 0,1,2,3,0 with no idle cycle between owners.
- Lock: grant to 2, then assert req[0] and req[3] while req[2] stays high for 20 cycles -> gnt stays 4'b0100. Drop req[2] -> next edge gnt=4'b1000 (ptr=3), then 4'b0001.
- Wrap/idle: grant 3, drop all req -> gnt=0, gnt_valid=0, gnt_id holds 3. Then req=4'b1001 -> gnt=4'b0001.
- Reset mid-grant: gnt=4'b0100 held, pulse reset=0 for one edge with req=4'b0110 -> gnt=0 that cycle, then gnt=4'b0010 (ptr reset to 0).
- Hold limit (macro defined, MAX_HOLD=4): req[1] held high from cycle 0, req[2] asserted at cycle 1 -> gnt=4'b0010 for exactly 5 cycles, then 4'b0100. With req[1] alone, the grant is held indefinitely.
